// File: rtl/rv32_pkg.sv
// Shared RV32I definitions used by the fetch unit and the control unit:
// instruction constants, major opcodes, fetch FSM states and buffer entry layout.
package rv32_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Fetches are always word aligned; the low two bits are simply cleared.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs between the memory
// side and the control unit. Flush wins over push and pop.
module fetch_buffer
    import rv32_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [31:0]   push_inst,
    input  logic [31:0]   push_pc,
    input  logic          pop,
    output logic          head_valid,
    output logic [31:0]   head_inst,
    output logic [31:0]   head_pc,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop on an empty buffer is ignored; a push on a full buffer only lands
    // when a pop frees the head in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are qualified by count so they need no reset
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
        end
    end

    assign head_valid = (count != '0);
    assign head_inst  = mem[rd_ptr].inst;
    assign head_pc    = mem[rd_ptr].pc;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word fetch at a time
// over req/gnt/rvalid, buffers returned words with their PC and hands them to
// the control unit under valid/ready. Redirects flush the buffer and squash
// the outstanding fetch.
module inst_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_err
);

    localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   pc;          // address of the next request to issue
    logic [31:0]   req_addr;    // address of the request currently on the bus / in flight
    logic          drop;        // in-flight word belongs to a squashed path
    logic [31:0]   redirect_tgt;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          head_valid;
    logic [31:0]   head_inst;
    logic [31:0]   head_pc;

    assign redirect_tgt = align_pc(redirect_pc);

    // A word returning in the same cycle as a redirect is stale and never stored.
    assign push = (state == S_WAIT) && imem_rvalid && !drop && !redirect_valid;
    assign pop  = head_valid && inst_ready && !redirect_valid;

    // Buffer occupancy once this cycle's push/pop/flush have taken effect.
    assign count_after = redirect_valid ? '0 : (count + CW'(push) - CW'(pop));

    fetch_buffer #(
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_inst  (imem_rdata),
        .push_pc    (req_addr),
        .pop        (pop),
        .head_valid (head_valid),
        .head_inst  (head_inst),
        .head_pc    (head_pc),
        .count      (count)
    );

    // Next-state and request decode; a request is only raised when its
    // returning word is guaranteed a buffer slot.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            S_IDLE: begin
                if ((count < FULL_CNT) || redirect_valid) state_nxt = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) state_nxt = (count_after < FULL_CNT) ? S_REQ : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // PC: redirect overrides; advance on a grant of a live (non-squashed) request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_tgt;
        end else if ((state == S_REQ) && imem_gnt && !drop) begin
            pc <= pc + 32'd4;
        end
    end

    // Latch the request address on entry to S_REQ so it holds until granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr <= RESET_PC;
        end else if ((state != S_REQ) && (state_nxt == S_REQ)) begin
            req_addr <= redirect_valid ? redirect_tgt : pc;
        end
    end

    // Squash flag for the single outstanding fetch; the returning word clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop <= 1'b0;
        end else if ((state == S_WAIT) && imem_rvalid) begin
            drop <= 1'b0;
        end else if (redirect_valid && ((state == S_REQ) || (state == S_WAIT))) begin
            drop <= 1'b1;
        end
    end

    // Misaligned redirect target flagged for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_err <= 1'b0;
        else        fetch_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end

    assign imem_addr  = req_addr;
    assign inst_valid = head_valid;
    assign inst       = head_valid ? head_inst : NOP_INST;
    assign inst_pc    = head_valid ? head_pc : 32'd0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios followed by a randomized run,
// all checked against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        fetch_err;

    inst_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: PCs of words the consumer should still receive, in order
    logic [31:0] q[$];
    logic [31:0] next_fetch;     // address the next live request must carry
    logic        stale = 1'b0;   // request on the bus was overtaken by a redirect
    logic        pending = 1'b0; // memory owes one word
    logic        taint = 1'b0;   // owed word belongs to a squashed path
    logic        exp_err = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] rv_addr = 32'd0;
    logic        last_gnt = 1'b0;
    logic [31:0] last_gnt_addr = 32'd0;
    int          rv_wait = 0;
    int          gnt_wait = 0;
    int          gnt_min = 0, gnt_max = 0, lat_min = 1, lat_max = 1;
    int          gcount = 0;
    int          delivered = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ (a << 5);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs, act as memory, advance the model, step the clock.
    task automatic cycle();
        logic keep;
        chk1("inst_valid", inst_valid, q.size() != 0);
        if (!inst_valid) begin
            chk32("idle_inst_nop", inst, NOP);
            chk32("idle_inst_pc", inst_pc, 32'd0);
        end
        chk1("fetch_err", fetch_err, exp_err);
        if (prev_hold) begin
            chk1("req_held", imem_req, 1'b1);
            chk32("addr_stable", imem_addr, prev_addr);
        end
        chk1("single_outstanding", pending && imem_req, 1'b0);

        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'd0;
        last_gnt = 1'b0;
        if (pending) begin
            if (rv_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(rv_addr);
            end
        end else if (imem_req && gnt_wait == 0) begin
            imem_gnt = 1'b1;
        end

        if (redirect_valid) begin
            q.delete();
        end else if (inst_valid && inst_ready && q.size() != 0) begin
            chk32("deliver_pc", inst_pc, q[0]);
            chk32("deliver_inst", inst, mem_word(q[0]));
            void'(q.pop_front());
            delivered++;
        end

        if (imem_rvalid) begin
            keep = !taint && !redirect_valid;
            pending = 1'b0;
            if (keep) begin
                q.push_back(rv_addr);
                chk1("no_overflow", q.size() <= DEPTH, 1'b1);
            end
        end else if (pending) begin
            rv_wait--;
            if (redirect_valid) taint = 1'b1;
        end

        if (imem_gnt) begin
            last_gnt = 1'b1;
            last_gnt_addr = imem_addr;
            gcount++;
            taint = stale || redirect_valid;
            if (stale) begin
                stale = 1'b0;
            end else begin
                chk32("gnt_addr", imem_addr, next_fetch);
                next_fetch = next_fetch + 32'd4;
            end
            pending = 1'b1;
            rv_addr = imem_addr;
            rv_wait = int'($urandom_range(lat_max, lat_min)) - 1;
            gnt_wait = int'($urandom_range(gnt_max, gnt_min));
        end else if (imem_req && !pending) begin
            if (gnt_wait > 0) gnt_wait--;
            if (redirect_valid) stale = 1'b1;
        end

        if (redirect_valid) next_fetch = {redirect_pc[31:2], 2'b00};
        exp_err = redirect_valid && (redirect_pc[1:0] != 2'b00);
        prev_hold = imem_req && !imem_gnt;
        prev_addr = imem_addr;

        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        cycle();
        redirect_valid = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must react at once.
    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk32("rst_addr", imem_addr, RESET_PC);
        chk1("rst_valid", inst_valid, 1'b0);
        chk32("rst_inst", inst, NOP);
        chk32("rst_pc", inst_pc, 32'd0);
        chk1("rst_err", fetch_err, 1'b0);
        q.delete();
        pending = 1'b0;
        stale = 1'b0;
        taint = 1'b0;
        exp_err = 1'b0;
        prev_hold = 1'b0;
        next_fetch = RESET_PC;
        gnt_wait = int'($urandom_range(gnt_max, gnt_min));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input string tag, output logic [31:0] a);
        a = 32'hDEAD_BEEF;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (last_gnt) begin
                a = last_gnt_addr;
                return;
            end
        end
        tests++;
        fails++;
        $error("FAIL %s: no grant within 64 cycles", tag);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 64; i++) begin
            if (inst_valid) return;
            cycle();
        end
        tests++;
        fails++;
        $error("FAIL %s: no inst_valid within 64 cycles", tag);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] t;
        int g0;
        int d0;

        // 1: single-cycle memory, sequential fetch and latency
        gnt_min = 0; gnt_max = 0; lat_min = 1; lat_max = 1;
        inst_ready = 1'b1;
        do_reset();
        chk1("t1_idle_after_reset", imem_req, 1'b0);
        cycle();
        chk1("t1_req", imem_req, 1'b1);
        chk32("t1_addr0", imem_addr, 32'd0);
        cycle();
        cycle();
        chk1("t1_valid", inst_valid, 1'b1);
        chk32("t1_inst", inst, 32'h0050_0093);
        chk32("t1_pc", inst_pc, 32'd0);
        wait_gnt("t1_gnt4", a);
        chk32("t1_addr4", a, 32'd4);
        wait_gnt("t1_gnt8", a);
        chk32("t1_addr8", a, 32'd8);
        repeat (6) cycle();
        d0 = delivered;
        repeat (20) cycle();
        chk32("t1_throughput", 32'(delivered - d0), 32'd10);

        // 2: consumer stalled, buffer fills then fetch halts
        inst_ready = 1'b0;
        do_reset();
        g0 = gcount;
        repeat (20) cycle();
        chk32("t2_grants", 32'(gcount - g0), 32'(DEPTH));
        chk1("t2_req_low", imem_req, 1'b0);
        chk32("t2_head_pc", inst_pc, 32'd0);
        inst_ready = 1'b1;
        wait_gnt("t2_resume", a);
        chk32("t2_resume_addr", a, 32'd8);
        repeat (10) cycle();

        // 3: redirect while waiting for read data
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (pending && rv_wait > 0) break;
            cycle();
        end
        redirect(32'h0000_0100);
        wait_gnt("t3_gnt", a);
        chk32("t3_addr", a, 32'h0000_0100);
        wait_valid("t3_valid");
        chk32("t3_first_pc", inst_pc, 32'h0000_0100);
        repeat (8) cycle();

        // 4: redirect while the request waits for a delayed grant
        gnt_min = 3; gnt_max = 3; lat_min = 1; lat_max = 1;
        do_reset();
        cycle();
        chk1("t4_req", imem_req, 1'b1);
        redirect(32'h0000_0100);
        gnt_min = 0; gnt_max = 0;
        wait_gnt("t4_stale_gnt", a);
        chk32("t4_stale_addr", a, RESET_PC);
        wait_gnt("t4_new_gnt", a);
        chk32("t4_new_addr", a, 32'h0000_0100);
        wait_valid("t4_valid");
        chk32("t4_first_pc", inst_pc, 32'h0000_0100);
        repeat (6) cycle();

        // 5: misaligned redirect target
        do_reset();
        redirect(32'h0000_0102);
        chk1("t5_err_pulse", fetch_err, 1'b1);
        chk1("t5_req", imem_req, 1'b1);
        chk32("t5_addr", imem_addr, 32'h0000_0100);
        cycle();
        chk1("t5_err_clear", fetch_err, 1'b0);
        wait_valid("t5_valid");
        chk32("t5_first_pc", inst_pc, 32'h0000_0100);

        // 6: reset while a fetch is in flight and the buffer is occupied
        inst_ready = 1'b0;
        lat_min = 4; lat_max = 4;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (pending && q.size() == 1) break;
            cycle();
        end
        lat_min = 1; lat_max = 1;
        do_reset();
        inst_ready = 1'b1;
        wait_gnt("t6_restart", a);
        chk32("t6_restart_addr", a, RESET_PC);
        repeat (6) cycle();

        // 7: PC wraps past the top of the address space
        do_reset();
        redirect(32'hFFFF_FFF8);
        wait_gnt("t7_g0", a);
        chk32("t7_addr0", a, 32'hFFFF_FFF8);
        wait_gnt("t7_g1", a);
        chk32("t7_addr1", a, 32'hFFFF_FFFC);
        wait_gnt("t7_g2", a);
        chk32("t7_addr2", a, 32'h0000_0000);
        repeat (6) cycle();

        // Randomized traffic: stalls, variable grant/data latency, redirects
        gnt_min = 0; gnt_max = 2; lat_min = 1; lat_max = 3;
        do_reset();
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            inst_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(15, 0) == 0) begin
                t = $urandom();
                if ($urandom_range(3, 0) != 0) t[1:0] = 2'b00;
                if ($urandom_range(7, 0) == 0) t[31:4] = 28'hFFFF_FFF;
                redirect(t);
            end else begin
                cycle();
            end
        end
        chk1("rand_progress", (delivered - d0) > 100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
